// File: rtl/vertex_fetch_if.sv
// rtl/vertex_fetch_if.sv - vertex RAM and vertex shader signals of vertex_fetch
interface vertex_fetch_if #(
  parameter int DATAWIDTH = 24,
  parameter int ADDRWIDTH = 12
);
  logic [ADDRWIDTH-1:0]           o_vram_addr;
  logic                           o_vram_re;
  logic [2:0][DATAWIDTH-1:0]      i_vram_data;
  logic                           i_enable;
  logic                           i_vs_ready;
  logic                           i_vs_finished;
  logic [3:0][3:0][DATAWIDTH-1:0] o_mvp_mat;
  logic                           o_mvp_dv;
  logic [2:0][DATAWIDTH-1:0]      o_vertex;
  logic                           o_vertex_dv;
  logic                           o_vertex_last;

  modport master (
    output o_vram_addr, o_vram_re, o_mvp_mat, o_mvp_dv,
           o_vertex, o_vertex_dv, o_vertex_last,
    input  i_vram_data, i_enable, i_vs_ready, i_vs_finished
  );

  modport slave (
    input  o_vram_addr, o_vram_re, o_mvp_mat, o_mvp_dv,
           o_vertex, o_vertex_dv, o_vertex_last,
    output i_vram_data, i_enable, i_vs_ready, i_vs_finished
  );
endinterface

// File: rtl/vertex_fetch.sv
// rtl/vertex_fetch.sv - pushes an MVP matrix then streams N vertices from RAM to the vertex shader
module vertex_fetch #(
  parameter int DATAWIDTH = 24,
  parameter int ADDRWIDTH = 12
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           i_start,
  input  logic [ADDRWIDTH-1:0]           i_num_vertices,
  input  logic [3:0][3:0][DATAWIDTH-1:0] i_mvp_mat,
  output logic                           o_busy,
  output logic                           o_done,
  vertex_fetch_if.master                 vs
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MVP,
    WAIT_READY,
    FETCH,
    DRAIN,
    WAIT_FIN,
    DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [ADDRWIDTH-1:0]           num_q, num_d;
  logic [ADDRWIDTH-1:0]           rd_addr_q, rd_addr_d;
  logic [3:0][3:0][DATAWIDTH-1:0] mvp_q, mvp_d;
  logic                           pending_q, pending_d;
  logic                           last_q, last_d;
  logic                           re;
  logic                           last_issue;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      num_q     <= '0;
      rd_addr_q <= '0;
      mvp_q     <= '0;
      pending_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      rd_addr_q <= rd_addr_d;
      mvp_q     <= mvp_d;
      pending_q <= pending_d;
      last_q    <= last_d;
    end
  end

  assign last_issue = (rd_addr_q == num_q - ADDRWIDTH'(1));

  // pending/last form the output stage; they only advance while the pipe is enabled
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    rd_addr_d = rd_addr_q;
    mvp_d     = mvp_q;
    pending_d = pending_q;
    last_d    = last_q;
    re        = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          num_d     = i_num_vertices;
          mvp_d     = i_mvp_mat;
          rd_addr_d = '0;
          pending_d = 1'b0;
          last_d    = 1'b0;
          state_d   = (i_num_vertices == '0) ? DONE : LOAD_MVP;
        end
      end
      LOAD_MVP: state_d = WAIT_READY;
      WAIT_READY: begin
        if (vs.i_vs_ready) state_d = FETCH;
      end
      FETCH: begin
        if (vs.i_enable) begin
          re        = 1'b1;
          rd_addr_d = rd_addr_q + ADDRWIDTH'(1);
          pending_d = 1'b1;
          last_d    = last_issue;
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (vs.i_enable) begin
          pending_d = 1'b0;
          last_d    = 1'b0;
          state_d   = WAIT_FIN;
        end
      end
      WAIT_FIN: begin
        if (vs.i_vs_finished) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_busy           = (state_q != IDLE);
  assign o_done           = (state_q == DONE);
  assign vs.o_mvp_dv      = (state_q == LOAD_MVP);
  assign vs.o_mvp_mat     = mvp_q;
  assign vs.o_vram_re     = re;
  assign vs.o_vram_addr   = rd_addr_q;
  assign vs.o_vertex      = vs.i_vram_data;
  assign vs.o_vertex_dv   = pending_q;
  assign vs.o_vertex_last = last_q;

endmodule

// File: tb/tb_vertex_fetch.sv
// tb/tb_vertex_fetch.sv - directed table-driven bench for vertex_fetch
module tb_vertex_fetch;
  localparam int DW = 24;
  localparam int AW = 12;

  typedef logic [3:0][3:0][DW-1:0] mat_t;
  typedef logic [2:0][DW-1:0]      vtx_t;

  typedef struct {
    int n;
    int ready_delay;
    int stall_idx;
    int stall_len;
    int fin_delay;
    int restart_n;
    bit spurious;
    int seed;
    int exp_done_lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_start;
  logic [AW-1:0] i_num;
  mat_t          i_mat;
  logic          o_busy;
  logic          o_done;
  vtx_t          ram_q = '0;

  int tests = 0;
  int fails = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  vertex_fetch_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) vif ();

  vertex_fetch #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_start        (i_start),
    .i_num_vertices (i_num),
    .i_mvp_mat      (i_mat),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .vs             (vif.master)
  );

  function automatic vtx_t vtx(input int k);
    vtx_t v;
    v[0] = DW'(k);
    v[1] = DW'(2 * k);
    v[2] = DW'(3 * k);
    return v;
  endfunction

  function automatic mat_t mk_mat(input int seed);
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = (r == c) ? DW'(24'h002000) : DW'(seed * (r * 4 + c));
    return m;
  endfunction

  // vertex RAM: one-cycle latency, output holds while not read
  always @(posedge clk) if (vif.o_vram_re) ram_q <= vtx(int'(vif.o_vram_addr));
  assign vif.i_vram_data = ram_q;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int c = 0;
    int mvp_cnt = 0, done_cnt = 0, re_cnt = 0, addr_bad = 0, accepted = 0;
    int mvp_cyc = -1, done_cyc = -1, ready_cyc = -1, first_re = -1, last_cyc = -1;
    int stall_left = 0;
    int exp_addr = 0;
    bit stalled = 0, restart_done = 0, spur_done = 0, stall_cyc;
    i_start = 1'b1;
    i_num   = AW'(v.n);
    i_mat   = mk_mat(v.seed);
    @(posedge clk); #1;
    i_start = 1'b0;
    c = 1;
    while (c < 300) begin
      vif.i_vs_ready = (mvp_cyc >= 0 && c > mvp_cyc + v.ready_delay);
      if (vif.i_vs_ready && ready_cyc < 0) ready_cyc = c;
      if (!stalled && v.stall_len > 0 && vif.o_vertex_dv && accepted == v.stall_idx) begin
        stalled    = 1;
        stall_left = v.stall_len;
      end
      vif.i_enable = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      vif.i_vs_finished = (last_cyc >= 0 && c == last_cyc + v.fin_delay);
      if (v.spurious && !spur_done && vif.o_vertex_dv && accepted == 0) begin
        vif.i_vs_finished = 1'b1;
        spur_done = 1;
      end
      i_start = (v.restart_n > 0 && !restart_done && vif.o_vertex_dv && accepted == 1);
      if (i_start) begin
        i_num = AW'(v.restart_n);
        restart_done = 1;
      end
      #1;
      stall_cyc = !vif.i_enable;
      if (vif.o_mvp_dv) begin
        mvp_cnt++;
        if (mvp_cyc < 0) mvp_cyc = c;
      end
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (vif.o_vram_re) begin
        if (int'(vif.o_vram_addr) != exp_addr) addr_bad++;
        exp_addr++;
        re_cnt++;
        if (first_re < 0) first_re = c;
      end
      if (stall_cyc) begin
        check("stall_dv", 384'(vif.o_vertex_dv), 384'(1'b1));
        check("stall_vertex", 384'(vif.o_vertex), 384'(vtx(v.stall_idx)));
        check("stall_re", 384'(vif.o_vram_re), 384'(1'b0));
        check("stall_addr", 384'(vif.o_vram_addr), 384'(v.stall_idx + 1));
      end else if (vif.o_vertex_dv) begin
        check($sformatf("vertex%0d", accepted), 384'(vif.o_vertex), 384'(vtx(accepted)));
        check($sformatf("last%0d", accepted), 384'(vif.o_vertex_last), 384'(accepted == v.n - 1));
        if (accepted == v.n - 1) last_cyc = c;
        accepted++;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        check("busy_after_done", 384'(o_busy), 384'(1'b0));
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    check("job_finished_in_budget", 384'(done_cyc >= 0), 384'(1'b1));
    check("vertex_count", 384'(accepted), 384'(v.n));
    check("read_count", 384'(re_cnt), 384'(v.n));
    check("read_addr_order", 384'(addr_bad), 384'(0));
    check("mvp_pulses", 384'(mvp_cnt), 384'(v.n > 0));
    check("done_pulses", 384'(done_cnt), 384'(1));
    if (v.n > 0) check("mvp_mat", 384'(vif.o_mvp_mat), 384'(mk_mat(v.seed)));
    if (v.ready_delay > 0) check("first_read_after_ready", 384'(first_re), 384'(ready_cyc + 1));
    if (v.exp_done_lat > 0) check("done_latency", 384'(done_cyc), 384'(v.exp_done_lat));
    vif.i_vs_ready    = 1'b0;
    vif.i_vs_finished = 1'b0;
    vif.i_enable      = 1'b1;
    i_start           = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n_done;
    int waited;
    vec_t v2;
    //        n  rdy sidx slen fin rst spur seed lat
    vecs[0] = '{4, 0,  0,   0,   6,  0,  0,   0,   14};
    vecs[1] = '{5, 0,  2,   3,   2,  0,  0,   3,   0};
    vecs[2] = '{0, 0,  0,   0,   1,  0,  0,   7,   1};
    vecs[3] = '{1, 0,  0,   0,   3,  0,  0,   2,   0};
    vecs[4] = '{3, 10, 0,   0,   1,  0,  0,   1,   0};
    vecs[5] = '{4, 0,  0,   0,   2,  7,  1,   5,   0};

    rstn = 1'b0;
    i_start = 1'b0;
    i_num = '0;
    i_mat = '0;
    vif.i_enable = 1'b1;
    vif.i_vs_ready = 1'b0;
    vif.i_vs_finished = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 384'(o_busy), 384'(1'b0));
    check("rst_done", 384'(o_done), 384'(1'b0));
    check("rst_outs", 384'({vif.o_vram_re, vif.o_vram_addr, vif.o_mvp_dv, vif.o_vertex_dv, vif.o_vertex_last}), 384'(0));
    check("rst_mvp_mat", 384'(vif.o_mvp_mat), 384'(0));
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // abort mid-fetch with reset
    i_start = 1'b1;
    i_num = AW'(4);
    i_mat = mk_mat(9);
    vif.i_vs_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    waited = 0;
    while (!vif.o_vertex_dv && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("reached_fetch", 384'(vif.o_vertex_dv), 384'(1'b1));
    rstn = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 384'(o_busy), 384'(1'b0));
    check("abort_done", 384'(o_done), 384'(1'b0));
    check("abort_outs", 384'({vif.o_vram_re, vif.o_vram_addr, vif.o_mvp_dv, vif.o_vertex_dv, vif.o_vertex_last}), 384'(0));
    check("abort_mvp_mat", 384'(vif.o_mvp_mat), 384'(0));
    rstn = 1'b1;
    vif.i_vs_ready = 1'b0;
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (o_done || o_busy) n_done++;
    end
    check("abort_no_done", 384'(n_done), 384'(0));

    v2 = '{2, 0, 0, 0, 2, 0, 0, 4, 0};
    run_job(v2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
